// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shifter and its command sequencer.
package univ_shift_pkg;

  // Shifter control encoding, common to univ_shifter and univ_shift_seq.
  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_RIGHT = 2'd1,
    SH_LEFT  = 2'd2,
    SH_LOAD  = 2'd3
  } shift_ctrl_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPT,
    RESP
  } seq_state_e;

  // Direction bit of a command mapped onto the shifter op (1 = left).
  function automatic shift_ctrl_e shift_op(input logic dir);
    return dir ? SH_LEFT : SH_RIGHT;
  endfunction

endpackage

// File: rtl/univ_shifter.sv
// Universal shifter: hold, zero-fill shift right/left, or parallel load.
// Output is registered; synchronous active-low reset.
module univ_shifter
  import univ_shift_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   control,
  input  logic [N-1:0] data,
  output logic [N-1:0] q
);

  // Apply the selected operation at each rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else begin
      case (shift_ctrl_e'(control))
        SH_RIGHT: q <= {1'b0, q[N-1:1]};
        SH_LEFT:  q <= {q[N-2:0], 1'b0};
        SH_LOAD:  q <= data;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/univ_shift_seq.sv
// Command sequencer in front of univ_shifter: one load cycle, amt shift
// cycles, a capture cycle, then a held valid/ready response.
// Optional feature macro: SEQ_PERF_CNT_EN adds the done_count output,
// a saturating count of response handshakes.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// LOAD  | shifter loads sh_data at the ending edge
// SHIFT | amt single-bit shifts, counter runs amt..1
// CAPT  | shifter settled, result captured at the ending edge
// RESP  | response held until rsp_ready
module univ_shift_seq
  import univ_shift_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_amount,
  output logic [1:0]       sh_control,
  output logic [N-1:0]     sh_data,
  input  logic [N-1:0]     sh_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
`ifdef SEQ_PERF_CNT_EN
  output logic [15:0]      done_count,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] AMT_MAX = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_e       state;
  shift_ctrl_e      ctrl_q;
  logic             dir_q;
  logic [CNT_W-1:0] amt_q;
  logic [CNT_W-1:0] cnt;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign sh_control = ctrl_q;

  // Sequencer FSM; shifter control is registered one state ahead so it is
  // valid for the whole cycle of the state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ctrl_q    <= SH_HOLD;
      sh_data   <= '0;
      dir_q     <= 1'b0;
      amt_q     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sh_data <= cmd_data;
            dir_q   <= cmd_dir;
            amt_q   <= (cmd_amount > AMT_MAX) ? AMT_MAX : cmd_amount;
            ctrl_q  <= SH_LOAD;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (amt_q != '0) begin
            cnt    <= amt_q;
            ctrl_q <= shift_op(dir_q);
            state  <= SHIFT;
          end else begin
            ctrl_q <= SH_HOLD;
            state  <= CAPT;
          end
        end
        SHIFT: begin
          if (cnt == CNT_ONE) begin
            ctrl_q <= SH_HOLD;
            state  <= CAPT;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        CAPT: begin
          rsp_data  <= sh_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          ctrl_q <= SH_HOLD;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Saturating count of completed response handshakes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_count <= '0;
    end else if (rsp_valid && rsp_ready && (done_count != 16'hFFFF)) begin
      done_count <= done_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_univ_shift_seq.sv
// Sequencer wired to univ_shifter; scoreboard of expected responses checked
// by an independent monitor on each rising rsp_valid.
module tb_univ_shift_seq;
  import univ_shift_pkg::*;

  localparam int N     = 16;
  localparam int CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [N-1:0]     cmd_data = '0;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_amount = '0;
  logic [1:0]       sh_control;
  logic [N-1:0]     sh_data;
  logic [N-1:0]     sh_out;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [N-1:0]     rsp_data;
  logic             busy;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0]      done_count;
`endif

  univ_shift_seq #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_dir(cmd_dir), .cmd_amount(cmd_amount),
    .sh_control(sh_control), .sh_data(sh_data), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef SEQ_PERF_CNT_EN
    .done_count(done_count),
`endif
    .busy(busy)
  );

  univ_shifter #(.N(N)) u_shifter (
    .clk(clk), .reset(reset), .control(sh_control), .data(sh_data), .q(sh_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] data;
    int           lat;
    int           acc;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] trace[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic       prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each new response is popped off the scoreboard and checked.
  always @(negedge clk) begin
    if (rsp_valid && !prev_v) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_data), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    prev_v = rsp_valid;
  end

  // Shifter control seen in every busy cycle.
  always @(negedge clk) if (busy) trace.push_back(sh_control);

  function automatic int shift_ops(input logic [1:0] op);
    int n = 0;
    foreach (trace[i]) if (trace[i] == op) n++;
    return n;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [N-1:0] d, input logic dir, input logic [CNT_W-1:0] amt,
                      input logic [N-1:0] exp, input int lat, input bit push, input bit keep);
    int  n = 0;
    cmd_valid  = 1'b1;
    cmd_data   = d;
    cmd_dir    = dir;
    cmd_amount = amt;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      if (push) sb.push_back('{data: exp, lat: lat, acc: cyc + 1});
      @(posedge clk);
      #1 if (!keep) cmd_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(sb.size() != 0 || busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_sh_control", 32'(sh_control), 32'd0);
    check("rst_sh_data", 32'(sh_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // 1: right shift by 4
    trace.delete();
    send(16'h00FF, 1'b0, 5'd4, 16'h000F, 6, 1'b1, 1'b0);
    wait_idle();
    check("t1_right_ops", 32'(shift_ops(2'b01)), 32'd4);

    // 2: left shift by 3, exact control trace
    trace.delete();
    send(16'h0080, 1'b1, 5'd3, 16'h0400, 5, 1'b1, 1'b0);
    wait_idle();
    check("t2_trace_len", 32'(trace.size() >= 5), 32'd1);
    if (trace.size() >= 5) begin
      check("t2_trace0", 32'(trace[0]), 32'h3);
      check("t2_trace1", 32'(trace[1]), 32'h2);
      check("t2_trace2", 32'(trace[2]), 32'h2);
      check("t2_trace3", 32'(trace[3]), 32'h2);
      check("t2_trace4", 32'(trace[4]), 32'h0);
    end

    // 3: zero amount, no shift op ever driven
    trace.delete();
    send(16'h1234, 1'b1, 5'd0, 16'h1234, 2, 1'b1, 1'b0);
    wait_idle();
    check("t3_shift_ops", 32'(shift_ops(2'b01) + shift_ops(2'b10)), 32'd0);

    // 4: amount above N clamps to N
    trace.delete();
    send(16'hFFFF, 1'b1, 5'd20, 16'h0000, 18, 1'b1, 1'b0);
    wait_idle();
    check("t4_left_ops", 32'(shift_ops(2'b10)), 32'd16);
    check("t4_right_ops", 32'(shift_ops(2'b01)), 32'd0);
`ifdef SEQ_PERF_CNT_EN
    check("done_count_4", 32'(done_count), 32'd4);
`endif

    // 5: backpressure with cmd_valid held high
    rsp_ready = 1'b0;
    send(16'hA5A5, 1'b0, 5'd2, 16'h2969, 4, 1'b1, 1'b1);
    cmd_data   = 16'h0001;
    cmd_dir    = 1'b1;
    cmd_amount = 5'd15;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_rsp_wait", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_data", 32'(rsp_data), 32'h2969);
      check("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check("t5_hold_ready", 32'(cmd_ready), 32'd0);
      check("t5_hold_ctrl", 32'(sh_control), 32'd0);
    end
    sb.push_back('{data: 16'h8000, lat: 17, acc: cyc + 2});
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_idle_bubble", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("t5_accepted", 32'(busy), 32'd1);
    wait_idle();

    // 6: reset during the second SHIFT cycle of an amount=8 command
    send(16'hFFFF, 1'b0, 5'd8, 16'h0000, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t6_in_shift", 32'(sh_control), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_sh_control", 32'(sh_control), 32'd0);
`ifdef SEQ_PERF_CNT_EN
    check("t6_done_count", 32'(done_count), 32'd0);
`endif
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_quiet", 32'(busy), 32'd0);

    // a clean command after the abort
    send(16'h8001, 1'b0, 5'd1, 16'h4000, 3, 1'b1, 1'b0);
    wait_idle();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
